// File: rtl/gtx_usrclk_pkg.sv
// Shared definitions for the GTX usrclk MMCM reset/lock sequencer.
// State encodings and counter sizing helper.
package gtx_usrclk_pkg;

    localparam logic [2:0] ST_HOLD      = 3'd0;
    localparam logic [2:0] ST_RST       = 3'd1;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [2:0] ST_STABLE    = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;
    localparam logic [2:0] ST_FAIL      = 3'd5;

    typedef enum logic [2:0] {
        S_HOLD      = ST_HOLD,
        S_RST       = ST_RST,
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_STABLE    = ST_STABLE,
        S_READY     = ST_READY,
        S_FAIL      = ST_FAIL
    } state_e;

    function automatic int cnt_w(input int v);
        return $clog2(v + 1);
    endfunction

endpackage

// File: rtl/gtx_usrclk_rst_ctrl_fsm.sv
// One MMCM reset/lock sequencer: input synchronizers, FSM and counters.
// Outputs are registered from the next state so they track the state register.
module gtx_mmcm_rst_fsm
    import gtx_usrclk_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int LOCK_STABLE  = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic soft_rst,
    input  logic clk_valid,
    input  logic mmcm_lock,
    output logic mmcm_reset,
    output logic usrclk_rdy,
    output logic fail
);

    localparam int RW = cnt_w(RST_CYCLES);
    localparam int TW = cnt_w(LOCK_TIMEOUT);
    localparam int SW = cnt_w(LOCK_STABLE);
    localparam int YW = cnt_w(MAX_RETRY);

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE - 1);
    localparam logic [YW-1:0] RETRY_MAX = YW'(MAX_RETRY);

    logic [1:0] vld_sync_q;
    logic [1:0] lck_sync_q;
    logic       valid_s;
    logic       lock_s;

    state_e          state_q, state_d;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [SW-1:0]   stb_cnt_q, stb_cnt_d;
    logic [YW-1:0]   retry_q, retry_d;
    logic            rst_q, rst_d;
    logic            rdy_q, rdy_d;
    logic            fail_q, fail_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sync_q <= '0;
            lck_sync_q <= '0;
        end else begin
            vld_sync_q <= {vld_sync_q[0], clk_valid};
            lck_sync_q <= {lck_sync_q[0], mmcm_lock};
        end
    end

    assign valid_s = vld_sync_q[1];
    assign lock_s  = lck_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HOLD;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            stb_cnt_q <= '0;
            retry_q   <= '0;
            rst_q     <= 1'b1;
            rdy_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            retry_q   <= retry_d;
            rst_q     <= rst_d;
            rdy_q     <= rdy_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        stb_cnt_d = stb_cnt_q;
        retry_d   = retry_q;

        // Restart and clock loss take priority over any lock activity
        if (soft_rst || (!valid_s && state_q != S_FAIL)) begin
            state_d   = S_HOLD;
            rst_cnt_d = '0;
            to_cnt_d  = '0;
            stb_cnt_d = '0;
            retry_d   = '0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    state_d = S_RST;
                end
                S_RST: begin
                    to_cnt_d  = '0;
                    stb_cnt_d = '0;
                    if (rst_cnt_q == RST_LAST) begin
                        rst_cnt_d = '0;
                        state_d   = S_WAIT_LOCK;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        stb_cnt_d = '0;
                        state_d   = S_STABLE;
                    end else if (to_cnt_q == TO_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_RST;
                        end
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        stb_cnt_d = '0;
                        state_d   = S_WAIT_LOCK;
                    end else if (stb_cnt_q == STB_LAST) begin
                        stb_cnt_d = '0;
                        retry_d   = '0;
                        state_d   = S_READY;
                    end else begin
                        stb_cnt_d = stb_cnt_q + 1'b1;
                    end
                end
                S_READY: begin
                    if (!lock_s) begin
                        rst_cnt_d = '0;
                        state_d   = S_RST;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end

        rst_d  = (state_d == S_HOLD) || (state_d == S_RST) ||
                 (state_d == S_FAIL);
        rdy_d  = (state_d == S_READY);
        fail_d = (state_d == S_FAIL);
    end

    assign mmcm_reset = rst_q;
    assign usrclk_rdy = rdy_q;
    assign fail       = fail_q;

endmodule

// File: rtl/gtx_usrclk_rst_ctrl.sv
// GTX usrclk MMCM reset/lock sequencer: one tx FSM and one or per-channel
// rx FSMs, with results broadcast across channels where shared.
module gtx_usrclk_rst_ctrl
    import gtx_usrclk_pkg::*;
#(
    parameter int    CHNL_NUM     = 8,
    parameter string BUFG_NUM     = "single",
    parameter int    RST_CYCLES   = 16,
    parameter int    LOCK_TIMEOUT = 1024,
    parameter int    LOCK_STABLE  = 8,
    parameter int    MAX_RETRY    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                soft_rst,
    input  logic [CHNL_NUM-1:0] tx_clk_valid,
    input  logic [CHNL_NUM-1:0] rx_clk_valid,
    input  logic [CHNL_NUM-1:0] tx_mmcm_lock,
    input  logic [CHNL_NUM-1:0] rx_mmcm_lock,
    output logic [CHNL_NUM-1:0] tx_mmcm_reset,
    output logic [CHNL_NUM-1:0] rx_mmcm_reset,
    output logic [CHNL_NUM-1:0] tx_usrclk_rdy,
    output logic [CHNL_NUM-1:0] rx_usrclk_rdy,
    output logic [CHNL_NUM-1:0] tx_fail,
    output logic [CHNL_NUM-1:0] rx_fail
);

    localparam bit MULTI = (BUFG_NUM == "multi");
    localparam int RX_N  = MULTI ? CHNL_NUM : 1;

    logic            tx_rst;
    logic            tx_rdy;
    logic            tx_fl;
    logic [RX_N-1:0] rx_rst;
    logic [RX_N-1:0] rx_rdy;
    logic [RX_N-1:0] rx_fl;

    gtx_mmcm_rst_fsm #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .MAX_RETRY    (MAX_RETRY)
    ) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .soft_rst   (soft_rst),
        .clk_valid  (tx_clk_valid[0]),
        .mmcm_lock  (tx_mmcm_lock[0]),
        .mmcm_reset (tx_rst),
        .usrclk_rdy (tx_rdy),
        .fail       (tx_fl)
    );

    for (genvar gi = 0; gi < RX_N; gi++) begin : g_rx
        gtx_mmcm_rst_fsm #(
            .RST_CYCLES   (RST_CYCLES),
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .LOCK_STABLE  (LOCK_STABLE),
            .MAX_RETRY    (MAX_RETRY)
        ) u_rx (
            .clk        (clk),
            .rst_n      (rst_n),
            .soft_rst   (soft_rst),
            .clk_valid  (rx_clk_valid[gi]),
            .mmcm_lock  (rx_mmcm_lock[gi]),
            .mmcm_reset (rx_rst[gi]),
            .usrclk_rdy (rx_rdy[gi]),
            .fail       (rx_fl[gi])
        );
    end

    assign tx_mmcm_reset = {CHNL_NUM{tx_rst}};
    assign tx_usrclk_rdy = {CHNL_NUM{tx_rdy}};
    assign tx_fail       = {CHNL_NUM{tx_fl}};

    if (MULTI) begin : g_multi
        assign rx_mmcm_reset = rx_rst;
        assign rx_usrclk_rdy = rx_rdy;
        assign rx_fail       = rx_fl;
    end else begin : g_single
        assign rx_mmcm_reset = {CHNL_NUM{rx_rst[0]}};
        assign rx_usrclk_rdy = {CHNL_NUM{rx_rdy[0]}};
        assign rx_fail       = {CHNL_NUM{rx_fl[0]}};
    end

    // Upper-channel inputs have no consumer when an FSM is shared
    if (CHNL_NUM > 1) begin : g_unused
        logic unused_tx;
        assign unused_tx = ^{tx_clk_valid[CHNL_NUM-1:1],
                             tx_mmcm_lock[CHNL_NUM-1:1]};
        if (!MULTI) begin : g_rx_unused
            logic unused_rx;
            assign unused_rx = ^{rx_clk_valid[CHNL_NUM-1:1],
                                 rx_mmcm_lock[CHNL_NUM-1:1]};
        end
    end

endmodule

// File: tb/tb_gtx_usrclk_rst_ctrl.sv
// Directed bench for gtx_usrclk_rst_ctrl: shared-BUFG sequence table,
// retry/fail and soft restart, and a per-channel rx instance.
module tb_gtx_usrclk_rst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       soft_s = 1'b0;
    logic       soft_m = 1'b0;
    logic [7:0] txv_s, rxv_s, txl_s, rxl_s;
    logic [7:0] txr_s, rxr_s, txy_s, rxy_s, txf_s, rxf_s;
    logic [7:0] txv_m, rxv_m, txl_m, rxl_m;
    logic [7:0] txr_m, rxr_m, txy_m, rxy_m, txf_m, rxf_m;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gtx_usrclk_rst_ctrl #(.CHNL_NUM(8), .BUFG_NUM("single")) dut_s (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_s),
        .tx_clk_valid(txv_s), .rx_clk_valid(rxv_s),
        .tx_mmcm_lock(txl_s), .rx_mmcm_lock(rxl_s),
        .tx_mmcm_reset(txr_s), .rx_mmcm_reset(rxr_s),
        .tx_usrclk_rdy(txy_s), .rx_usrclk_rdy(rxy_s),
        .tx_fail(txf_s), .rx_fail(rxf_s)
    );

    gtx_usrclk_rst_ctrl #(.CHNL_NUM(8), .BUFG_NUM("multi")) dut_m (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_m),
        .tx_clk_valid(txv_m), .rx_clk_valid(rxv_m),
        .tx_mmcm_lock(txl_m), .rx_mmcm_lock(rxl_m),
        .tx_mmcm_reset(txr_m), .rx_mmcm_reset(rxr_m),
        .tx_usrclk_rdy(txy_m), .rx_usrclk_rdy(rxy_m),
        .tx_fail(txf_m), .rx_fail(rxf_m)
    );

    typedef struct {
        int   n;
        logic valid;
        logic lock;
        logic e_rst;
        logic e_rdy;
        logic e_fail;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] obs_s();
        return {txr_s, rxr_s, txy_s, rxy_s, txf_s, rxf_s};
    endfunction

    task automatic drive_s(input logic v, input logic l);
        txv_s = {7'b0, v};
        rxv_s = {7'b0, v};
        txl_s = {7'b0, l};
        rxl_s = {7'b0, l};
    endtask

    initial begin
        int widths[$];
        int gaps[$];
        int run;
        int cnt;
        logic prev;
        logic cur;
        bit done;
        logic [47:0] exp;

        //             n  vld   lck   rst   rdy   fail
        tv.push_back('{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tv.push_back('{17, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tv.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        tv.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        tv.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        tv.push_back('{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        tv.push_back('{15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        tv.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        tv.push_back('{2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        tv.push_back('{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tv.push_back('{16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tv.push_back('{27, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tv.push_back('{18, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tv.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0});

        drive_s(1'b1, 1'b0);
        txv_m = 8'hFF;
        rxv_m = 8'hFF;
        txl_m = 8'hFF;
        rxl_m = 8'hF7;

        repeat (3) @(negedge clk);
        check("reset_state", {16'h0, obs_s()}, {16'h0, 16'hFFFF, 32'h0});
        rst_n = 1'b1;

        foreach (tv[i]) begin
            drive_s(tv[i].valid, tv[i].lock);
            repeat (tv[i].n) @(negedge clk);
            exp = {{16{tv[i].e_rst}}, {16{tv[i].e_rdy}},
                   {16{tv[i].e_fail}}};
            check($sformatf("vec%0d", i), {16'h0, obs_s()}, {16'h0, exp});
        end

        check("multi_rdy_early", {32'h0, rxy_m, rxf_m, txy_m, txf_m},
              {32'h0, 8'hF7, 8'h00, 8'hFF, 8'h00});

        // Lock lost for good: one pulse from READY plus three retries
        drive_s(1'b1, 1'b0);
        run = 0;
        prev = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 6000 && !done; c++) begin
            @(negedge clk);
            cur = txr_s[0];
            if (txf_s[0]) begin
                done = 1'b1;
                if (!prev) gaps.push_back(run);
            end else begin
                if (cur == prev) begin
                    run++;
                end else begin
                    if (prev) widths.push_back(run);
                    else if (widths.size() > 0) gaps.push_back(run);
                    run = 1;
                end
                prev = cur;
            end
        end
        check("fail_reached", {63'h0, done}, 64'h1);
        check("pulse_count", widths.size(), 4);
        foreach (widths[i]) check($sformatf("pulse_w%0d", i), widths[i], 16);
        check("gap_count", gaps.size(), 4);
        foreach (gaps[i]) check($sformatf("gap%0d", i), gaps[i], 1024);

        repeat (20) @(negedge clk);
        check("fail_sticky", {16'h0, obs_s()},
              {16'h0, 16'hFFFF, 16'h0, 16'hFFFF});

        soft_s = 1'b1;
        @(negedge clk);
        soft_s = 1'b0;
        check("soft_clears_fail", {16'h0, obs_s()},
              {16'h0, 16'hFFFF, 32'h0});
        repeat (16) @(negedge clk);
        check("soft_rst_high", {48'h0, txr_s, rxr_s}, {48'h0, 16'hFFFF});
        @(negedge clk);
        check("soft_rst_low", {48'h0, txr_s, rxr_s}, 64'h0);

        drive_s(1'b1, 1'b1);
        cnt = 0;
        while (txy_s[0] !== 1'b1 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("relock_latency", cnt, 11);
        check("relock_bcast", {48'h0, txy_s, rxy_s}, {48'h0, 16'hFFFF});

        check("multi_final", {16'h0, rxy_m, rxf_m, rxr_m, txy_m, txf_m, txr_m},
              {16'h0, 8'hF7, 8'h08, 8'h08, 8'hFF, 8'h00, 8'h00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
